// File: rtl/i2c_moni_pkg.sv
// i2c_moni_pkg
// Shared definitions for the I2C event decoder.
// Contents:
//   - Event-type encoding (EV_START, EV_RSTART, EV_STOP, EV_BYTE) and its width.
//   - Bit offsets of the fields inside one FIFO record.
//   - The decoder FSM state encoding.
// Record layout, LSB first:
//   type[1:0] | data[9:2] | ack[10] | timestamp[11 +: TS_W] (timestamp build only)
package i2c_moni_pkg;

  localparam int EV_TYPE_W = 2;

  typedef enum logic [EV_TYPE_W-1:0] {
    EV_START  = 2'd0,
    EV_RSTART = 2'd1,
    EV_STOP   = 2'd2,
    EV_BYTE   = 2'd3
  } ev_type_e;

  localparam int REC_TYPE_LSB = 0;
  localparam int REC_DATA_LSB = 2;
  localparam int REC_ACK_BIT  = 10;
  localparam int REC_TS_LSB   = 11;
  localparam int REC_BASE_W   = 11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BITS = 1'b1
  } dec_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter
// Brings one raw, asynchronous I2C line into the clock domain and removes glitches.
//   - Two-flop synchroniser, reset to 1 (an idle bus is high).
//   - The filtered output follows the synchronised value only after FILT_LEN
//     consecutive differing samples. Any matching sample restarts the count.
// Parameters: FILT_LEN (1..15).
// Ports:
//   clk   - system clock
//   res_n - asynchronous active-low reset
//   raw   - raw line input (asynchronous)
//   filt  - filtered line, resets to 1
module i2c_line_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic res_n,
  input  logic raw,
  output logic filt
);

  logic [1:0] sync_reg;
  logic [3:0] cnt_reg;
  logic       filt_reg;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync_reg <= 2'b11;
      cnt_reg  <= '0;
      filt_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[0], raw};
      if (sync_reg[1] == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == 4'(FILT_LEN - 1)) begin
        // This is the FILT_LEN-th differing sample in a row: accept the new level.
        filt_reg <= sync_reg[1];
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + 4'd1;
      end
    end
  end

  assign filt = filt_reg;

endmodule

// File: rtl/i2c_event_decoder.sv
// i2c_event_decoder
// Passive I2C bus decoder. It turns filtered SCL/SDA activity into START, RSTART,
// STOP and BYTE+ACK records, queues them in a show-ahead FIFO and hands them out
// over a valid/ready interface.
//
// Build option:
//   I2C_DEC_TIMESTAMP_EN
//     defined:   each record also stores i_timestamp, and o_ev_ts comes from the FIFO.
//     undefined: records are 11 bits wide and o_ev_ts is tied to 0.
//
// Ports:
//   i_clk, i_res_n            clock; asynchronous active-low reset
//   i_en                      decoder enable (0 holds the FSM idle, no pushes)
//   i_i2c_scl, i_i2c_sda      raw bus lines
//   i_timestamp               free-running timestamp
//   o_ev_valid, i_ev_ready    record handshake
//   o_ev_type/data/ack/ts     head record (all 0 while empty)
//   o_level                   FIFO occupancy
//   o_overflow, i_ovf_clr     sticky drop flag and its clear
//   o_frame_err               one-cycle pulse when a partial byte is aborted
module i2c_event_decoder
  import i2c_moni_pkg::*;
#(
  parameter int FILT_LEN   = 4,
  parameter int TS_W       = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_res_n,
  input  logic                          i_en,
  input  logic                          i_i2c_scl,
  input  logic                          i_i2c_sda,
  input  logic [TS_W-1:0]               i_timestamp,
  output logic                          o_ev_valid,
  input  logic                          i_ev_ready,
  output logic [1:0]                    o_ev_type,
  output logic [7:0]                    o_ev_data,
  output logic                          o_ev_ack,
  output logic [TS_W-1:0]               o_ev_ts,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow,
  input  logic                          i_ovf_clr,
  output logic                          o_frame_err
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = AW + 1;
`ifdef I2C_DEC_TIMESTAMP_EN
  localparam int REC_W = REC_BASE_W + TS_W;
`else
  localparam int REC_W = REC_BASE_W;
`endif

  // ---------------- line conditioning ----------------
  // Bit 0 is SCL, bit 1 is SDA.
  logic [1:0] raw_lines;
  logic [1:0] filt_lines;

  assign raw_lines = {i_i2c_sda, i_i2c_scl};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
        .clk   (i_clk),
        .res_n (i_res_n),
        .raw   (raw_lines[gi]),
        .filt  (filt_lines[gi])
      );
    end
  endgenerate

  // cur is one register behind the filter output, and prev is one behind cur.
  logic [1:0] cur_reg;
  logic [1:0] prev_reg;

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      cur_reg  <= 2'b11;
      prev_reg <= 2'b11;
    end else begin
      cur_reg  <= filt_lines;
      prev_reg <= cur_reg;
    end
  end

  logic scl_cur, scl_prev, sda_cur, sda_prev;
  logic start_det, stop_det, scl_rise;

  assign scl_cur  = cur_reg[0];
  assign scl_prev = prev_reg[0];
  assign sda_cur  = cur_reg[1];
  assign sda_prev = prev_reg[1];

  // START/STOP require SCL to be steady high. If SCL moved in the same cycle,
  // the change is treated as a clock edge and no START/STOP is reported.
  assign start_det = scl_prev & scl_cur & sda_prev & ~sda_cur;
  assign stop_det  = scl_prev & scl_cur & ~sda_prev & sda_cur;
  assign scl_rise  = ~scl_prev & scl_cur;

  // ---------------- decoder FSM ----------------
  dec_state_e state_reg, state_next;
  logic [3:0] bitcnt_reg, bitcnt_next;
  logic [7:0] shift_reg, shift_next;
  logic       frame_err_reg, frame_err_next;

  logic       push_req;
  ev_type_e   push_type;
  logic [7:0] push_data;
  logic       push_ack;

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state_reg     <= ST_IDLE;
      bitcnt_reg    <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bitcnt_reg    <= bitcnt_next;
      shift_reg     <= shift_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bitcnt_next    = bitcnt_reg;
    shift_next     = shift_reg;
    frame_err_next = 1'b0;
    push_req       = 1'b0;
    push_type      = EV_START;
    push_data      = 8'h00;
    push_ack       = 1'b0;

    if (!i_en) begin
      state_next  = ST_IDLE;
      bitcnt_next = '0;
    end else if (start_det) begin
      push_req       = 1'b1;
      push_type      = (state_reg == ST_IDLE) ? EV_START : EV_RSTART;
      frame_err_next = (bitcnt_reg != 4'd0);
      state_next     = ST_BITS;
      bitcnt_next    = '0;
      shift_next     = '0;
    end else if (stop_det) begin
      if (state_reg != ST_IDLE) begin
        push_req       = 1'b1;
        push_type      = EV_STOP;
        frame_err_next = (bitcnt_reg != 4'd0);
      end
      state_next  = ST_IDLE;
      bitcnt_next = '0;
    end else if (scl_rise && state_reg == ST_BITS) begin
      if (bitcnt_reg == 4'd8) begin
        // Ninth clock: the ACK slot. SDA held low means the byte was acknowledged.
        push_req    = 1'b1;
        push_type   = EV_BYTE;
        push_data   = shift_reg;
        push_ack    = ~sda_cur;
        bitcnt_next = '0;
      end else begin
        shift_next  = {shift_reg[6:0], sda_cur};
        bitcnt_next = bitcnt_reg + 4'd1;
      end
    end
  end

  assign o_frame_err = frame_err_reg;

  // ---------------- event FIFO ----------------
  logic [REC_W-1:0]   push_rec;
  logic [REC_W-1:0]   mem [FIFO_DEPTH];
  logic [REC_W-1:0]   head;
  logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [LEVEL_W-1:0] level_reg;
  logic               ovf_reg;
  logic               full, empty, pop, push_ok, drop;

  always_comb begin
    push_rec = '0;
    push_rec[REC_TYPE_LSB +: EV_TYPE_W] = push_type;
    push_rec[REC_DATA_LSB +: 8]         = push_data;
    push_rec[REC_ACK_BIT]               = push_ack;
`ifdef I2C_DEC_TIMESTAMP_EN
    push_rec[REC_TS_LSB +: TS_W]        = i_timestamp;
`endif
  end

  assign full    = (level_reg == LEVEL_W'(FIFO_DEPTH));
  assign empty   = (level_reg == '0);
  assign pop     = ~empty & i_ev_ready;
  // When the FIFO is full, a push is still accepted if a pop frees a slot in the same cycle.
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  // The storage is also cleared on reset, so no stale record can ever reach the outputs.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr_reg] <= push_rec;
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)           ovf_reg <= 1'b1;
      else if (i_ovf_clr) ovf_reg <= 1'b0;
    end
  end

  assign head       = mem[rd_ptr_reg];
  assign o_ev_valid = ~empty;
  assign o_ev_type  = empty ? 2'd0 : head[REC_TYPE_LSB +: EV_TYPE_W];
  assign o_ev_data  = empty ? 8'd0 : head[REC_DATA_LSB +: 8];
  assign o_ev_ack   = empty ? 1'b0 : head[REC_ACK_BIT];
  assign o_level    = level_reg;
  assign o_overflow = ovf_reg;

`ifdef I2C_DEC_TIMESTAMP_EN
  assign o_ev_ts = empty ? '0 : head[REC_TS_LSB +: TS_W];
`else
  logic unused_ts;
  assign unused_ts = ^i_timestamp;
  assign o_ev_ts   = '0;
`endif

endmodule

// File: tb/tb_i2c_event_decoder.sv
// Directed testbench for i2c_event_decoder (FILT_LEN=4, FIFO_DEPTH=16).
// The bench drives I2C bus phases, drains the recorded events and compares them
// with hand-written expected records. It prints one line per drained record.
module tb_i2c_event_decoder;

  localparam int FILT_LEN   = 4;
  localparam int TS_W       = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int HOLD       = 10;

  logic            clk = 1'b0;
  logic            rst_n, en, scl, sda, ev_ready, ovf_clr;
  logic [TS_W-1:0] ts = '0;
  logic            ev_valid, ev_ack, overflow, frame_err;
  logic [1:0]      ev_type;
  logic [7:0]      ev_data;
  logic [TS_W-1:0] ev_ts;
  logic [4:0]      level;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;

  i2c_event_decoder #(.FILT_LEN(FILT_LEN), .TS_W(TS_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk(clk), .i_res_n(rst_n), .i_en(en), .i_i2c_scl(scl), .i_i2c_sda(sda),
    .i_timestamp(ts), .o_ev_valid(ev_valid), .i_ev_ready(ev_ready),
    .o_ev_type(ev_type), .o_ev_data(ev_data), .o_ev_ack(ev_ack), .o_ev_ts(ev_ts),
    .o_level(level), .o_overflow(overflow), .i_ovf_clr(ovf_clr), .o_frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ts <= ts + 1;
  always @(negedge clk) if (frame_err) fe_cnt++;

  typedef struct packed {
    logic       op;        // 0 = byte, 1 = repeated START
    logic [7:0] data;
    logic       nack;
    logic [1:0] exp_type;
    logic [7:0] exp_data;
    logic       exp_ack;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda = 1'b0; cyc(HOLD);
    scl = 1'b0; cyc(HOLD);
  endtask

  task automatic i2c_bit(input logic b);
    sda = b;    cyc(HOLD);
    scl = 1'b1; cyc(HOLD);
    scl = 1'b0; cyc(HOLD);
  endtask

  task automatic i2c_byte(input logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) i2c_bit(d[i]);
    i2c_bit(nack);
  endtask

  task automatic i2c_rstart();
    sda = 1'b1; cyc(HOLD);
    scl = 1'b1; cyc(HOLD);
    sda = 1'b0; cyc(HOLD);
    scl = 1'b0; cyc(HOLD);
  endtask

  task automatic i2c_stop();
    sda = 1'b0; cyc(HOLD);
    scl = 1'b1; cyc(HOLD);
    sda = 1'b1; cyc(HOLD);
  endtask

  // Wait for a head record, sample it away from the edge, then accept it.
  task automatic expect_rec(input string name, input logic [1:0] t,
                            input logic [7:0] d, input logic a);
    bit got = 0;
    logic [1:0] at;
    logic [7:0] ad;
    logic       aa;
    at = '0;
    ad = '0;
    aa = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (ev_valid) begin
        at = ev_type; ad = ev_data; aa = ev_ack; got = 1;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s: no record within 200 cycles, expected type %0d", name, t);
    end else begin
      $display("rec %s: type=%0d data=0x%02h ack=%0d", name, at, ad, aa);
      chk({name, ".type"}, 32'(at), 32'(t));
      chk({name, ".data"}, 32'(ad), 32'(d));
      chk({name, ".ack"},  32'(aa), 32'(a));
      ev_ready = 1'b1;
      @(posedge clk);
      #1 ev_ready = 1'b0;
    end
  endtask

  initial begin
    int n;
    bit seen;
    logic [7:0] bd;

    vecs[0] = '{1'b0, 8'h91, 1'b0, 2'd3, 8'h91, 1'b1};
    vecs[1] = '{1'b1, 8'h00, 1'b0, 2'd1, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 8'h55, 1'b1, 2'd3, 8'h55, 1'b0};
    vecs[3] = '{1'b0, 8'hFF, 1'b0, 2'd3, 8'hFF, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 2'd3, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 8'h00, 1'b0, 2'd1, 8'h00, 1'b0};
    vecs[6] = '{1'b0, 8'h3C, 1'b0, 2'd3, 8'h3C, 1'b1};

    rst_n = 1'b0; en = 1'b1; scl = 1'b1; sda = 1'b1; ev_ready = 1'b0; ovf_clr = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(HOLD);

    // Reset state
    chk("rst.valid", 32'(ev_valid), 0);
    chk("rst.level", 32'(level), 0);
    chk("rst.ovf",   32'(overflow), 0);
    chk("rst.ferr",  32'(frame_err), 0);
    chk("rst.type",  32'(ev_type), 0);
    chk("rst.data",  32'(ev_data), 0);
    chk("rst.ts",    32'(ev_ts), 0);

    // Write 0xA0 + ACK, then STOP, measuring START latency
    sda = 1'b0;   // driven 1 time unit after a rising edge
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ev_valid) seen = 1;
    end
    chk("lat.start", 32'(n), 32'(FILT_LEN + 4));
    cyc(HOLD);
    scl = 1'b0; cyc(HOLD);
    i2c_byte(8'hA0, 1'b0);
    i2c_stop();
    cyc(HOLD);
    chk("a0.level", 32'(level), 3);
    expect_rec("a0.start", 2'd0, 8'h00, 1'b0);
    expect_rec("a0.byte",  2'd3, 8'hA0, 1'b1);
    expect_rec("a0.stop",  2'd2, 8'h00, 1'b0);

    // Table-driven transaction: bytes and repeated STARTs
    i2c_start();
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].op) i2c_rstart();
      else            i2c_byte(vecs[i].data, vecs[i].nack);
    end
    i2c_stop();
    cyc(HOLD);
    chk("tab.level", 32'(level), 9);
    expect_rec("tab.start", 2'd0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++)
      expect_rec($sformatf("tab%0d", i), vecs[i].exp_type, vecs[i].exp_data, vecs[i].exp_ack);
    expect_rec("tab.stop", 2'd2, 8'h00, 1'b0);
    cyc(2);
    chk("tab.empty", 32'(level), 0);

    // Glitches: 3-cycle pulses rejected, 4-cycle SDA pulse accepted
    scl = 1'b0; cyc(3); scl = 1'b1; cyc(20);
    sda = 1'b0; cyc(3); sda = 1'b1; cyc(20);
    chk("glitch3.level", 32'(level), 0);
    sda = 1'b0; cyc(4); sda = 1'b1; cyc(20);
    chk("glitch4.level", 32'(level), 2);
    expect_rec("glitch4.start", 2'd0, 8'h00, 1'b0);
    expect_rec("glitch4.stop",  2'd2, 8'h00, 1'b0);

    // Partial byte (5 bits) aborted by STOP
    fe_cnt = 0;
    i2c_start();
    for (int i = 0; i < 5; i++) i2c_bit(i[0]);
    i2c_stop();
    cyc(HOLD);
    chk("abort.ferr_pulses", 32'(fe_cnt), 1);
    chk("abort.level", 32'(level), 2);
    expect_rec("abort.start", 2'd0, 8'h00, 1'b0);
    expect_rec("abort.stop",  2'd2, 8'h00, 1'b0);

    // Decoder disabled: bus activity produces no records
    en = 1'b0;
    sda = 1'b0; cyc(HOLD); sda = 1'b1; cyc(HOLD);
    chk("dis.level", 32'(level), 0);
    en = 1'b1;
    cyc(HOLD);

    // Overflow: 20 events with ready held low
    i2c_start();
    for (int k = 0; k < 18; k++) begin
      bd = 8'(k * 17) ^ 8'hA5;
      i2c_byte(bd, k[0]);
    end
    i2c_stop();
    cyc(HOLD);
    chk("ovf.level", 32'(level), 16);
    chk("ovf.flag",  32'(overflow), 1);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf.cleared", 32'(overflow), 0);
    cyc(1);
    expect_rec("ovf.start", 2'd0, 8'h00, 1'b0);
    for (int k = 0; k < 15; k++) begin
      bd = 8'(k * 17) ^ 8'hA5;
      expect_rec($sformatf("ovf%0d", k), 2'd3, bd, ~k[0]);
    end
    cyc(2);
    chk("ovf.drained", 32'(level), 0);
    chk("ovf.valid",   32'(ev_valid), 0);

    // Reset in the middle of a byte, then a fresh transaction
    i2c_start();
    for (int i = 0; i < 4; i++) i2c_bit(1'b1);
    chk("mid.level", 32'(level), 1);
    rst_n = 1'b0;
    scl = 1'b1; sda = 1'b1;
    #2;
    chk("mid.async_level", 32'(level), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(HOLD);
    chk("mid.valid", 32'(ev_valid), 0);
    i2c_start();
    i2c_byte(8'h5A, 1'b0);
    i2c_stop();
    cyc(HOLD);
    chk("post.level", 32'(level), 3);
    expect_rec("post.start", 2'd0, 8'h00, 1'b0);
    expect_rec("post.byte",  2'd3, 8'h5A, 1'b1);
    expect_rec("post.stop",  2'd2, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
